// File: rtl/shift_reg_seq.sv
// Load sequencer for a bidirectional serial-in shift register: serialises a host word
// onto sin_r/sin_l over WIDTH clocks, then captures the register's Q and compares it.
module shift_reg_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             mode,
  output logic             sin_r,
  output logic             sin_l,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [WIDTH-1:0] q_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             mode_q,  mode_d;
  logic             sin_r_q, sin_r_d;
  logic             sin_l_q, sin_l_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sin_r_q <= 1'b0;
      sin_l_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      q_out_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sin_r_q <= sin_r_d;
      sin_l_q <= sin_l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      q_out_q <= q_out_d;
    end
  end

  // sh_q is a working copy of the word that is shifted out one bit per edge, so the
  // next serial bit always sits at sh_q[0] (right) or sh_q[WIDTH-1] (left).
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sin_r_d = 1'b0;
    sin_l_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    q_out_d = q_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          word_d  = data_in;
          mode_d  = dir;
          busy_d  = 1'b1;
          cnt_d   = '0;
          if (dir) begin
            sin_r_d = data_in[0];
            sh_d    = data_in >> 1;
          end else begin
            sin_l_d = data_in[WIDTH-1];
            sh_d    = data_in << 1;
          end
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = CHECK;
        end else if (mode_q) begin
          sin_r_d = sh_q[0];
          sh_d    = sh_q >> 1;
        end else begin
          sin_l_d = sh_q[WIDTH-1];
          sh_d    = sh_q << 1;
        end
      end

      CHECK: begin
        q_out_d = q_in;
        match_d = (q_in == word_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mode  = mode_q;
  assign sin_r = sin_r_q;
  assign sin_l = sin_l_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign match = match_q;
  assign q_out = q_out_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq with a behavioural shift_reg attached to its outputs.
module tb_shift_reg_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         dir;
  logic [W-1:0] data_in;
  logic [W-1:0] q_in;
  logic         mode, sin_r, sin_l, busy, done, match;
  logic [W-1:0] q_out;

  logic [W-1:0] sr_q = '0;
  logic         force_q2 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_reg_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .data_in (data_in),
    .q_in    (q_in),
    .mode    (mode),
    .sin_r   (sin_r),
    .sin_l   (sin_l),
    .busy    (busy),
    .done    (done),
    .match   (match),
    .q_out   (q_out)
  );

  // External register: shifts every edge, right when mode=1, left when mode=0.
  always_ff @(posedge clk) begin
    if (mode) sr_q <= {sin_r, sr_q[W-1:1]};
    else      sr_q <= {sr_q[W-2:0], sin_l};
  end
  assign q_in = force_q2 ? (sr_q & 4'b1011) : sr_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_seq holds the serial bits in drive order, first bit in the MSB.
  task automatic load(input string tag, input logic d, input logic [W-1:0] w,
                      input logic [W-1:0] exp_seq, input logic [W-1:0] exp_q,
                      input logic exp_m, input logic glitch);
    start = 1'b1; dir = d; data_in = w;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (glitch && i == 1) begin
        start = 1'b1; dir = ~d; data_in = 4'b0110;
      end else begin
        start = 1'b0;
      end
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_mode"}, mode, d);
      check({tag, "_done"}, done, 1'b0);
      if (d) begin
        check({tag, "_sinr"}, sin_r, exp_seq[W-1-i]);
        check({tag, "_sinl0"}, sin_l, 1'b0);
      end else begin
        check({tag, "_sinl"}, sin_l, exp_seq[W-1-i]);
        check({tag, "_sinr0"}, sin_r, 1'b0);
      end
      step();
    end
    start = 1'b0;
    check({tag, "_chk_busy"}, busy, 1'b1);
    check({tag, "_chk_done"}, done, 1'b0);
    check({tag, "_chk_sin"}, {sin_r, sin_l}, 2'b00);
    step();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_qout"}, q_out, exp_q);
    check({tag, "_match"}, match, exp_m);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dir = 1'b0; data_in = '0;

    // 1: reset values, then idle with start low
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_qout", q_out, 4'b0000);
    check("rst_mode", mode, 1'b0);
    check("rst_sin", {sin_r, sin_l}, 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_out", {mode, sin_r, sin_l, match, q_out}, 8'h00);
    end

    // 2: right load 1010 -> sin_r 0,1,0,1
    load("right", 1'b1, 4'b1010, 4'b0101, 4'b1010, 1'b1, 1'b0);
    step();
    check("right_done_pulse", done, 1'b0);
    check("right_qout_hold", q_out, 4'b1010);
    check("right_match_hold", match, 1'b1);
    check("idle_mode_hold", mode, 1'b1);

    // 3: left load 1101 -> sin_l 1,1,0,1
    load("left", 1'b0, 4'b1101, 4'b1101, 4'b1101, 1'b1, 1'b0);
    step();
    check("left_done_pulse", done, 1'b0);

    // 4: start re-pulsed mid-load is ignored; start held in done cycle is accepted
    load("ign", 1'b1, 4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b1);
    load("b2b", 1'b1, 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b0);
    step();
    check("b2b_done_pulse", done, 1'b0);

    // 5: reset mid-load of 1111
    start = 1'b1; dir = 1'b1; data_in = 4'b1111;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sinr", sin_r, 1'b0);
    check("mid_rst_qout", q_out, 4'b0000);
    check("mid_rst_match", match, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_rst_nodone", done, 1'b0);
    end
    reset = 1'b1;
    step();
    load("after_rst", 1'b1, 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b0);
    step();

    // 6: Q[2] stuck at 0 during a load of 0100
    force_q2 = 1'b1;
    load("stuck", 1'b1, 4'b0100, 4'b0010, 4'b0000, 1'b0, 1'b0);
    step();
    check("stuck_done_once", done, 1'b0);
    check("stuck_match_hold", match, 1'b0);
    force_q2 = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
